add_mw_ctrl: RTL and testbench

//  Multi-word add sequencer. Drives one external N-bit ripple adder (FA_1bit chain,

---
 rtl/add_mw_ctrl.sv | 125 ++++++++++++
 tb/tb_add_mw_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/add_mw_ctrl.sv
// Multi-word add sequencer: drives one external N-bit adder LSW-first over WORDS cycles.
// Latency: accept edge + WORDS edges; done_o is high in the cycle after edge WORDS.
// No backpressure: start_i is ignored while busy_o=1; accepted in IDLE or DONE.
// Optional subtract mode is enabled with `define ADD_MW_SUB_EN (adds port sub_i).
module add_mw_ctrl #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
`ifdef ADD_MW_SUB_EN
  input  logic                 sub_i,
`endif
  input  logic [N*WORDS-1:0]   a_i,
  input  logic [N*WORDS-1:0]   b_i,
  output logic [N-1:0]         add_a_o,
  output logic [N-1:0]         add_b_o,
  output logic                 add_cin_o,
  input  logic [N-1:0]         add_sum_i,
  input  logic                 add_cout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N*WORDS-1:0]   sum_o,
  output logic                 carry_o
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
`ifdef ADD_MW_SUB_EN
  logic            sub_q;
`endif

  // Sequencer: accept, walk words LSW-first capturing sum and inter-word carry, then pulse done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
`ifdef ADD_MW_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state   <= RUN;
            busy_o  <= 1'b1;
            a_q     <= a_i;
            b_q     <= b_i;
            idx     <= '0;
`ifdef ADD_MW_SUB_EN
            sub_q   <= sub_i;
            // Two's-complement subtract: invert B words and seed the chain with 1
            carry_q <= sub_i;
`else
            carry_q <= 1'b0;
`endif
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        RUN: begin
          sum_q[int'(idx)*N +: N] <= add_sum_i;
          carry_q                 <= add_cout_i;
          if (idx == LAST) begin
            // idx parks at the last word; the next accept reloads it
            state   <= DONE;
            carry_o <= add_cout_i;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  // Adder operand mux: current word in RUN, quiet zeros otherwise
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    if (state == RUN) begin
      add_a_o   = a_q[int'(idx)*N +: N];
`ifdef ADD_MW_SUB_EN
      add_b_o   = sub_q ? ~b_q[int'(idx)*N +: N] : b_q[int'(idx)*N +: N];
`else
      add_b_o   = b_q[int'(idx)*N +: N];
`endif
      add_cin_o = carry_q;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: tb/tb_add_mw_ctrl.sv
module tb_add_mw_ctrl;

  localparam int N     = 8;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [W-1:0]  a_in, b_in;
  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          busy, done;
  logic [W-1:0]  sum;
  logic          carry;

  int checks = 0;
  int errors = 0;

  // Per-op observations recorded by run_op
  int            lat;
  int            busy_cnt;
  logic [WORDS-1:0] cin_trace;

  always #5 clk = ~clk;

  // External ripple adder model (combinational)
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  add_mw_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
`ifdef ADD_MW_SUB_EN
    .sub_i      (sub),
`endif
    .a_i        (a_in),
    .b_i        (b_in),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout),
    .busy_o     (busy),
    .done_o     (done),
    .sum_o      (sum),
    .carry_o    (carry)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sb);
    if (sb) return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Called just after a negedge; drives start for one cycle and waits for done (bounded)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
    logic [W:0] exp;
    exp       = ref_result(a, b, sb);
    start     = 1'b1;
    a_in      = a;
    b_in      = b;
    sub       = sb;
    lat       = 0;
    busy_cnt  = 0;
    cin_trace = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      if (busy) begin
        if (busy_cnt < WORDS) cin_trace[busy_cnt] = add_cin;
        busy_cnt++;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 64'd0, 64'd1);
    check("latency", 64'(lat), 64'(WORDS + 1));
    check("busy_cycles", 64'(busy_cnt), 64'(WORDS));
    check("sum", 64'(sum), 64'(exp[W-1:0]));
    check("carry", 64'(carry), 64'(exp[W]));
    check("done_busy_low", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   e1, e2;
    logic         rs;
    int           dcnt;
    int           gap;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {busy, done, carry, add_cin, 12'd0, add_a, add_b},
          64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: carry propagates word0 -> word1
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("t1_cin_trace", 64'(cin_trace), 64'b0010);
    @(negedge clk);
    check("t1_done_single", 64'(done), 64'd0);
    check("t1_idle_adder", {add_a, add_b, 7'd0, add_cin}, 64'd0);

    // 2: full carry-out
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("t2_cin_trace", 64'(cin_trace), 64'b1110);
    @(negedge clk);

    // 3: start held through RUN with changing operands; second op accepted in DONE
    e1 = ref_result(32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
    e2 = ref_result(32'h8000_0001, 32'h8000_00FF, 1'b0);
    start = 1'b1;
    a_in  = 32'h1234_5678;
    b_in  = 32'h0F0F_0F0F;
    lat   = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      a_in = 32'h8000_0001;
      b_in = 32'h8000_00FF;
      if (done) begin lat = i; break; end
    end
    check("t3_lat1", 64'(lat), 64'd5);
    check("t3_sum1", 64'(sum), 64'(e1[W-1:0]));
    check("t3_carry1", 64'(carry), 64'(e1[W]));
    @(negedge clk);
    start = 1'b0;
    check("t3_rerun_busy", 64'(busy), 64'd1);
    check("t3_rerun_done", 64'(done), 64'd0);
    lat = 0;
    for (int i = 2; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
    end
    check("t3_lat2", 64'(lat), 64'd5);
    check("t3_sum2", 64'(sum), 64'(e2[W-1:0]));
    check("t3_carry2", 64'(carry), 64'(e2[W]));
    @(negedge clk);

    // 4: reset at idx=2 aborts the op
    start = 1'b1;
    a_in  = 32'hFFFF_FFFF;
    b_in  = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_pre_cin", 64'(add_cin), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_outs", {busy, done, carry, add_cin, 12'd0, add_a, add_b}, 64'd0);
    check("t4_rst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("t4_no_done", 64'(dcnt), 64'd0);
    run_op(32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    @(negedge clk);

`ifdef ADD_MW_SUB_EN
    // 5: subtract
    run_op(32'd5, 32'd7, 1'b1);
    check("t5_sub_neg", {31'd0, carry, sum}, {31'd0, 1'b0, 32'hFFFF_FFFE});
    @(negedge clk);
    run_op(32'd7, 32'd5, 1'b1);
    check("t5_sub_pos", {31'd0, carry, sum}, {31'd0, 1'b1, 32'h0000_0002});
    @(negedge clk);
`endif

    // 6: random ops with random gaps (gap 0 = back-to-back)
    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
`ifdef ADD_MW_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (g == 0) check("rand_done_pulse", 64'(done), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
